gpu_op_scheduler: RTL and testbench

GPU_OP_SCHEDULER -- requirements
Module: gpu_op_scheduler

---
 rtl/gpu_pkg.sv | 14 +
 rtl/gpu_sched_watchdog.sv | 41 ++++
 rtl/gpu_op_scheduler.sv | 133 +++++++++++++
 tb/tb_gpu_op_scheduler.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared op type and scheduler state encoding for the GPU op scheduler
package gpu_pkg;

  localparam int GPU_OP_W = 62;

  typedef logic [GPU_OP_W-1:0] gpu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DONE  = 2'd2
  } gpu_sched_state_t;

endpackage

// File: rtl/gpu_sched_watchdog.sv
// rtl/gpu_sched_watchdog.sv - idle-cycle counter that flags a stuck producer after WATCHDOG_CYCLES-1 idle cycles
module gpu_sched_watchdog #(
  parameter int WATCHDOG_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ce_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic expire_o
);

  localparam int CW = $clog2(WATCHDOG_CYCLES) + 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // Expiry fires on the idle cycle whose increment would bring the count to WATCHDOG_CYCLES-1
  assign expire_o = ce_i & inc_i & ((cnt_q + CW'(1)) == CW'(WATCHDOG_CYCLES - 1));

  // Next count: clear on handshake/grant change/swap or expiry, otherwise count idle cycles
  always_comb begin
    cnt_d = cnt_q;
    if (ce_i) begin
      if (clr_i || expire_o) begin
        cnt_d = '0;
      end else if (inc_i) begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gpu_op_scheduler.sv
// rtl/gpu_op_scheduler.sv - in-order per-frame op scheduler into the GPU FIFO; watchdog option GPU_SCHED_WATCHDOG_EN
module gpu_op_scheduler
  import gpu_pkg::*;
#(
  parameter  int N_REQ           = 3,
  parameter  int WATCHDOG_CYCLES = 1024,
  localparam int GW              = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic                 swap,
  input  logic [N_REQ-1:0]     req_valid,
  input  gpu_op_t [N_REQ-1:0]  req_op,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 fifo_wr_en,
  output gpu_op_t              fifo_wr_data,
  input  logic                 fifo_full,
  output logic [GW-1:0]        grant_idx,
  output logic                 busy,
`ifdef GPU_SCHED_WATCHDOG_EN
  output logic [N_REQ-1:0]     wd_err,
`endif
  output logic                 frame_done
);

  localparam logic [GW-1:0] LAST_IDX = GW'(N_REQ - 1);

  gpu_sched_state_t state_q, state_d;
  logic [GW-1:0]    grant_q, grant_d;
  logic             frame_done_q, frame_done_d;
  logic             hs;
  logic             finish;
  logic             wd_expire;

  // Only the granted producer may be accepted, never while full or in a swap cycle
  always_comb begin
    req_ready = '0;
    if (ce && (state_q == ST_GRANT) && !fifo_full && !swap) begin
      req_ready[grant_q] = 1'b1;
    end
  end

  assign hs           = req_valid[grant_q] & req_ready[grant_q];
  assign fifo_wr_en   = hs;
  assign fifo_wr_data = req_op[grant_q];
  assign grant_idx    = grant_q;
  assign busy         = (state_q == ST_GRANT);
  assign frame_done   = frame_done_q;

`ifdef GPU_SCHED_WATCHDOG_EN
  logic [N_REQ-1:0] wd_err_q, wd_err_d;
  logic             wd_idle;

  // Idle means the granted producer has nothing to offer; full stalls are not the producer's fault
  assign wd_idle = ce & (state_q == ST_GRANT) & ~req_valid[grant_q] & ~fifo_full & ~swap;

  gpu_sched_watchdog #(
    .WATCHDOG_CYCLES (WATCHDOG_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .ce_i     (ce),
    .clr_i    (swap | hs),
    .inc_i    (wd_idle),
    .expire_o (wd_expire)
  );

  // Sticky per-producer timeout flags, cleared only by a new frame
  always_comb begin
    wd_err_d = wd_err_q;
    if (ce) begin
      if (swap) begin
        wd_err_d = '0;
      end else if (wd_expire) begin
        wd_err_d[grant_q] = 1'b1;
      end
    end
  end

  // Timeout flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_err_q <= '0;
    end else begin
      wd_err_q <= wd_err_d;
    end
  end

  assign wd_err = wd_err_q;
`else
  assign wd_expire = 1'b0;
`endif

  // A producer is finished by its last op or by a watchdog timeout
  assign finish = (hs & req_last[grant_q]) | wd_expire;

  // Next-state: swap restarts the frame, finishing a producer advances the grant
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    frame_done_d = frame_done_q;
    if (ce) begin
      frame_done_d = 1'b0;
      if (swap) begin
        state_d = ST_GRANT;
        grant_d = '0;
      end else if ((state_q == ST_GRANT) && finish) begin
        if (grant_q == LAST_IDX) begin
          state_d      = ST_DONE;
          frame_done_d = 1'b1;
        end else begin
          grant_d = grant_q + GW'(1);
        end
      end
    end
  end

  // State, grant and frame-done registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_gpu_op_scheduler.sv
// tb/tb_gpu_op_scheduler.sv - randomized scoreboard bench for gpu_op_scheduler
module tb_gpu_op_scheduler;
  import gpu_pkg::*;

  localparam int N  = 3;
  localparam int WD = 16;

  logic             clk = 1'b0;
  logic             rst_n, ce, swap, fifo_full;
  logic [N-1:0]     req_valid, req_last, req_ready;
  gpu_op_t [N-1:0]  req_op;
  logic             fifo_wr_en;
  gpu_op_t          fifo_wr_data;
  logic [1:0]       grant_idx;
  logic             busy, frame_done;
`ifdef GPU_SCHED_WATCHDOG_EN
  logic [N-1:0]     wd_err;
`endif

  always #5 clk = ~clk;

  gpu_op_scheduler #(
    .N_REQ           (N),
    .WATCHDOG_CYCLES (WD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ce           (ce),
    .swap         (swap),
    .req_valid    (req_valid),
    .req_op       (req_op),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .fifo_full    (fifo_full),
    .grant_idx    (grant_idx),
    .busy         (busy),
`ifdef GPU_SCHED_WATCHDOG_EN
    .wd_err       (wd_err),
`endif
    .frame_done   (frame_done)
  );

  int errors = 0;
  int checks = 0;

  // Reference: each producer's pending ops, and the frame's expected FIFO order
  gpu_op_t pq [N][$];
  gpu_op_t exp_q[$];
  int      m_grant;
  bit      m_busy;
  bit      m_done_next;
  int      wr_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_frame(input int a, input int b, input int c);
    int n[N];
    logic [63:0] r;
    n[0] = a; n[1] = b; n[2] = c;
    exp_q.delete();
    for (int p = 0; p < N; p++) begin
      pq[p].delete();
      for (int k = 0; k < n[p]; k++) begin
        r = {$urandom, $urandom};
        pq[p].push_back(r[61:0]);
        exp_q.push_back(r[61:0]);
      end
    end
  endtask

  task automatic drive(input int vpct);
    for (int p = 0; p < N; p++) begin
      if (pq[p].size() > 0) begin
        req_op[p]    = pq[p][0];
        req_last[p]  = (pq[p].size() == 1);
        req_valid[p] = ($urandom_range(99) < vpct);
      end else begin
        req_op[p]    = '0;
        req_last[p]  = 1'b0;
        req_valid[p] = 1'b0;
      end
    end
  endtask

  // mode: 0 plain, 1 five-cycle full stall on P1's second op, 2 ce low 4 cycles in P1, 3 swap abort in P1
  task automatic run_frame(input int a, input int b, input int c, input int vpct, input int fpct, input int mode);
    int  cyc, stall, cel, p1_acc;
    bit  post, aborted, abort_now, abort_first;
    load_frame(a, b, c);
    wr_cnt = 0;
    @(posedge clk); #1;
    swap = 1'b1; ce = 1'b1; fifo_full = 1'b0; drive(100);
    @(negedge clk);
    check("swap_no_wr", fifo_wr_en, 0);
    check("swap_no_ready", req_ready, 0);
    m_grant = 0; m_busy = 1'b1; m_done_next = 1'b0;
    cyc = 0; stall = 0; cel = 0; p1_acc = 0;
    aborted = 1'b0; abort_first = 1'b0;
    while ((m_busy || m_done_next) && cyc < 2000) begin
      @(posedge clk); #1;
      swap = 1'b0; ce = 1'b1; post = 1'b0; abort_now = 1'b0;
      fifo_full = ($urandom_range(99) < fpct);
      drive(vpct);
      if (mode == 1 && m_grant == 1 && p1_acc == 1) begin
        req_valid[1] = 1'b1;
        if (stall < 5) begin
          fifo_full = 1'b1;
          stall++;
        end else begin
          fifo_full = 1'b0;
          post = 1'b1;
        end
      end
      if (mode == 2 && m_grant == 1 && cel < 4) begin
        ce = 1'b0; req_valid = '1; cel++;
      end
      if (mode == 3 && !aborted && m_grant == 1 && p1_acc == 1) begin
        swap = 1'b1; aborted = 1'b1; abort_now = 1'b1;
      end
      if (abort_first) begin
        fifo_full = 1'b0; req_valid[0] = 1'b1;
      end
      @(negedge clk);
      check("frame_done", frame_done, m_done_next);
      check("busy", busy, m_busy);
      m_done_next = 1'b0;
      if (m_busy) check("grant", grant_idx, m_grant);
      if (fifo_full) check("wr_while_full", fifo_wr_en, 0);
      if (!ce) check("ce_low_ready", {fifo_wr_en, req_ready}, 0);
      if (post) check("wr_after_stall", fifo_wr_en, 1);
      if (abort_first) begin
        check("abort_p0_first", fifo_wr_en, 1);
        abort_first = 1'b0;
      end
      if (abort_now) begin
        check("abort_no_wr", fifo_wr_en, 0);
        load_frame(a, b, c);
        m_grant = 0; p1_acc = 0; abort_first = 1'b1;
      end else if (fifo_wr_en) begin
        if (!m_busy || exp_q.size() == 0) begin
          check("unexpected_wr", 1, 0);
        end else begin
          wr_cnt++;
          check("ready_sel", req_ready, 64'(1) << m_grant);
          check("wr_data", fifo_wr_data, exp_q.pop_front());
          void'(pq[m_grant].pop_front());
          if (m_grant == 1) p1_acc++;
          if (pq[m_grant].size() == 0) begin
            if (m_grant == N - 1) begin
              m_busy = 1'b0; m_done_next = 1'b1;
            end else begin
              m_grant++;
            end
          end
        end
      end
      cyc++;
    end
    check("frame_in_budget", cyc < 2000, 1);
    check("frame_all_written", exp_q.size(), 0);
    repeat (3) begin
      @(posedge clk); #1;
      fifo_full = 1'b0; req_valid = '1;
      @(negedge clk);
      check("done_no_wr", fifo_wr_en, 0);
      check("done_grant_hold", grant_idx, N - 1);
      check("done_no_pulse", frame_done, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; ce = 1'b1; swap = 1'b0; fifo_full = 1'b0;
    req_valid = '0; req_last = '0; req_op = '0;
    #12;
    check("rst_outputs", {busy, grant_idx, frame_done, fifo_wr_en, req_ready}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    repeat (3) begin
      @(posedge clk); #1;
      req_valid = '1; req_last = '1;
      @(negedge clk);
      check("idle_no_wr", fifo_wr_en, 0);
    end

    run_frame(2, 3, 1, 100, 0, 0);
    check("basic_write_count", wr_cnt, 6);
    run_frame(2, 3, 1, 100, 0, 1);
    check("stall_write_count", wr_cnt, 6);
    run_frame(2, 3, 1, 100, 0, 2);
    check("ce_write_count", wr_cnt, 6);
    run_frame(2, 3, 1, 100, 0, 3);

    // asynchronous reset in the middle of a frame
    load_frame(3, 3, 3);
    @(posedge clk); #1; swap = 1'b1;
    @(posedge clk); #1; swap = 1'b0; drive(100);
    @(negedge clk);
    check("pre_rst_busy", busy, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_outputs", {busy, grant_idx, frame_done, fifo_wr_en, req_ready}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      drive(100);
      @(negedge clk);
      check("post_rst_no_wr", fifo_wr_en, 0);
    end

    for (int r = 0; r < 6; r++) begin
      run_frame($urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 4), 70, 25, 0);
    end

`ifdef GPU_SCHED_WATCHDOG_EN
    begin
      int n;
      @(posedge clk); #1;
      swap = 1'b1; ce = 1'b1; fifo_full = 1'b0; req_valid = '0; req_last = '0;
      @(posedge clk); #1;
      swap = 1'b0; req_valid = 3'b001; req_last = 3'b001; req_op[0] = 62'h1234;
      @(negedge clk);
      check("wd_p0_wr", fifo_wr_en, 1);
      n = 0;
      while (n < 40) begin
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        if (grant_idx != 2'd1) break;
        n++;
      end
      check("wd_idle_cycles", n, 15);
      check("wd_err_set", wd_err, 3'b010);
      check("wd_grant_p2", grant_idx, 2);
      @(posedge clk); #1;
      req_valid = 3'b100; req_last = 3'b100; req_op[2] = 62'h5678;
      @(negedge clk);
      check("wd_p2_wr", {fifo_wr_en, fifo_wr_data}, {1'b1, 62'h5678});
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      check("wd_frame_done", {frame_done, busy}, 2'b10);
      @(posedge clk); #1;
      swap = 1'b1;
      @(posedge clk); #1;
      swap = 1'b0;
      @(negedge clk);
      check("wd_err_clear", wd_err, 0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
